// File: rtl/spi_master_tx_if.sv
// Handshake and serial-bus bundle for spi_master_tx.
// The master modport is the transmitter's view; slave is the host/bench view.
interface spi_master_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  SS;
    logic                  SCLK;
    logic                  MOSI;
    logic                  busy;
    logic                  done;

    modport master (
        input  tx_data, tx_valid,
        output tx_ready, SS, SCLK, MOSI, busy, done
    );

    modport slave (
        output tx_data, tx_valid,
        input  tx_ready, SS, SCLK, MOSI, busy, done
    );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 transmit-only master: sends LEAD_BITS zeros then a DATA_WIDTH payload MSB first.
// Every output is a register that reflects the current state.
module spi_master_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4,
    parameter int LEAD_BITS  = 1,
    parameter int GAP_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    spi_master_tx_if.master  bus
);
    localparam int NW = LEAD_BITS + DATA_WIDTH;
    localparam int BW = $clog2(NW + 1);
    // The IDLE accept cycle also keeps SS high, so GAP itself covers one cycle fewer.
    localparam int GAP_LEN = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 1;

    localparam logic [7:0]    DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0]    GAP_LOAD = 8'(GAP_LEN - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NW - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   shreg_q, shreg_d;
    logic [7:0]      div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [7:0]      gap_q, gap_d;
    logic            ss_q, ss_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [NW-1:0]   loadWord;
    logic [NW-1:0]   shifted;

    assign loadWord = NW'(bus.tx_data);
    assign shifted  = shreg_q << 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            ss_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            ss_q    <= ss_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        ss_d    = ss_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ready_q && bus.tx_valid) begin
                    state_d = SETUP;
                    shreg_d = loadWord;
                    mosi_d  = loadWord[NW-1];
                    ss_d    = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = DIV_LOAD;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (div_q == 8'd0) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    div_d   = DIV_LOAD;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            SHIFT: begin
                // MOSI advances only together with the SCLK fall.
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else if (sclk_q) begin
                    sclk_d  = 1'b0;
                    div_d   = DIV_LOAD;
                    shreg_d = shifted;
                    mosi_d  = shifted[NW-1];
                end else if (bit_q == BIT_LAST) begin
                    state_d = HOLD;
                    div_d   = DIV_LOAD;
                end else begin
                    bit_d  = bit_q + BW'(1);
                    sclk_d = 1'b1;
                    div_d  = DIV_LOAD;
                end
            end
            HOLD: begin
                if (div_q == 8'd0) begin
                    state_d = GAP;
                    ss_d    = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    gap_d   = GAP_LOAD;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign bus.tx_ready = ready_q;
    assign bus.SS       = ss_q;
    assign bus.SCLK     = sclk_q;
    assign bus.MOSI     = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx: a default instance and a CLK_DIV=1 instance,
// observed by a bus monitor and compared against transfer-level expectations.
module tb_spi_master_tx;
    localparam int DW   = 32;
    localparam int LEAD = 1;
    localparam int NB   = LEAD + DW;
    localparam int DIV0 = 4;
    localparam int DIV1 = 1;
    localparam int GAP  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_master_tx_if #(.DATA_WIDTH(DW)) ifc0 ();
    spi_master_tx_if #(.DATA_WIDTH(DW)) ifc1 ();

    spi_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(DIV0), .LEAD_BITS(LEAD), .GAP_CYCLES(GAP)) dut0 (
        .clk(clk), .reset(reset), .bus(ifc0)
    );
    spi_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(DIV1), .LEAD_BITS(LEAD), .GAP_CYCLES(GAP)) dut1 (
        .clk(clk), .reset(reset), .bus(ifc1)
    );

    logic [1:0] ssV, sclkV, mosiV, readyV, busyV, doneV, validV;
    assign ssV    = {ifc1.SS, ifc0.SS};
    assign sclkV  = {ifc1.SCLK, ifc0.SCLK};
    assign mosiV  = {ifc1.MOSI, ifc0.MOSI};
    assign readyV = {ifc1.tx_ready, ifc0.tx_ready};
    assign busyV  = {ifc1.busy, ifc0.busy};
    assign doneV  = {ifc1.done, ifc0.done};
    assign validV = {ifc1.tx_valid, ifc0.tx_valid};

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int acceptCyc[2], acceptCnt[2], doneCyc[2], doneCnt[2], ssFallCyc[2];
    int riseCnt[2], lastRise[2], badPeriod[2], badMosi[2];
    int ssHighRun[2], readyRun[2], lastGap[2], lastReady[2];
    logic [63:0] capWord[2];
    logic [1:0] pS = 2'b00, pM = 2'b00, pSs = 2'b11;

    function automatic int divOf(int d);
        return (d == 0) ? DIV0 : DIV1;
    endfunction

    function automatic int expLatency(int div, int n);
        return 1 + div + 2 * div * n + div;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: records accepts, done pulses, SS edges, and the MOSI bit seen at each SCLK rise.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (validV[d] && readyV[d]) begin
                acceptCyc[d] <= cyc;
                acceptCnt[d] <= acceptCnt[d] + 1;
            end
            if (doneV[d]) begin
                doneCyc[d] <= cyc;
                doneCnt[d] <= doneCnt[d] + 1;
            end
            if (ssV[d]) begin
                ssHighRun[d] <= ssHighRun[d] + 1;
                if (readyV[d]) readyRun[d] <= readyRun[d] + 1;
            end
            if (pSs[d] && !ssV[d]) begin
                ssFallCyc[d] <= cyc;
                lastGap[d]   <= ssHighRun[d];
                lastReady[d] <= readyRun[d];
                ssHighRun[d] <= 0;
                readyRun[d]  <= 0;
                riseCnt[d]   <= 0;
                capWord[d]   <= '0;
            end else if (!pS[d] && sclkV[d]) begin
                riseCnt[d] <= riseCnt[d] + 1;
                capWord[d] <= {capWord[d][62:0], mosiV[d]};
                if (riseCnt[d] > 0 && (cyc - lastRise[d]) != 2 * divOf(d))
                    badPeriod[d] <= badPeriod[d] + 1;
                lastRise[d] <= cyc;
            end
            if (mosiV[d] != pM[d] && !(pS[d] && !sclkV[d]) && (ssV[d] == pSs[d]))
                badMosi[d] <= badMosi[d] + 1;
        end
        pS  <= sclkV;
        pM  <= mosiV;
        pSs <= ssV;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input int d, input logic valid, input logic [DW-1:0] data);
        if (d == 0) begin
            ifc0.tx_valid = valid;
            ifc0.tx_data  = data;
        end else begin
            ifc1.tx_valid = valid;
            ifc1.tx_data  = data;
        end
    endtask

    // Presents a word and returns just after the accepting clock edge.
    task automatic applyStimulus(input int d, input logic [DW-1:0] data, input bit hold);
        int start;
        start = acceptCnt[d];
        @(posedge clk);
        #2;
        drive(d, 1'b1, data);
        for (int i = 0; i < 50 && acceptCnt[d] == start; i++) tick();
        checkOutput("accept_seen", 64'(acceptCnt[d] - start), 64'd1);
        @(posedge clk);
        #2;
        if (!hold) drive(d, 1'b0, data);
    endtask

    task automatic waitDone(input int d);
        int start;
        start = doneCnt[d];
        for (int i = 0; i < 400 && doneCnt[d] == start; i++) tick();
        checkOutput("done_seen", 64'(doneCnt[d] - start), 64'd1);
    endtask

    task automatic checkTransfer(input int d, input logic [DW-1:0] data);
        checkOutput("latency", 64'(doneCyc[d] - acceptCyc[d]), 64'(expLatency(divOf(d), NB)));
        checkOutput("ss_fall_delay", 64'(ssFallCyc[d] - acceptCyc[d]), 64'd1);
        checkOutput("sclk_rises", 64'(riseCnt[d]), 64'(NB));
        checkOutput("mosi_bits", capWord[d], {32'd0, data});
        checkOutput("mosi_only_on_fall", 64'(badMosi[d]), 64'd0);
        checkOutput("sclk_period", 64'(badPeriod[d]), 64'd0);
        tick();
        checkOutput("done_one_cycle", {61'd0, doneV[d], ssV[d], busyV[d]}, 64'b011);
    endtask

    initial begin
        logic [DW-1:0] rnd;
        int target;
        int startAcc;
        int startDone;

        reset = 1'b1;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        #2 reset = 1'b0;
        tick();
        checkOutput("reset_outs_dut0", {58'd0, ssV[0], sclkV[0], mosiV[0], readyV[0], busyV[0], doneV[0]}, 64'b100000);
        checkOutput("reset_outs_dut1", {58'd0, ssV[1], sclkV[1], mosiV[1], readyV[1], busyV[1], doneV[1]}, 64'b100000);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        tick();
        checkOutput("ready_after_reset", {63'd0, readyV[0]}, 64'd1);

        $display("[TB] directed word A5C30F81");
        applyStimulus(0, 32'hA5C3_0F81, 1'b0);
        waitDone(0);
        checkTransfer(0, 32'hA5C3_0F81);

        $display("[TB] loopback word DEADBEEF");
        applyStimulus(0, 32'hDEAD_BEEF, 1'b0);
        waitDone(0);
        checkOutput("loopback_din", capWord[0] & 64'hFFFF_FFFF, 64'hDEAD_BEEF);
        checkTransfer(0, 32'hDEAD_BEEF);

        $display("[TB] tx_data change during transfer");
        applyStimulus(0, 32'h0, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        drive(0, 1'b0, 32'hFFFF_FFFF);
        waitDone(0);
        checkTransfer(0, 32'h0);

        $display("[TB] random words");
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            rnd = $urandom;
            applyStimulus(0, rnd, 1'b0);
            waitDone(0);
            checkTransfer(0, rnd);
        end

        $display("[TB] back-to-back with tx_valid held");
        startAcc = acceptCnt[0];
        applyStimulus(0, 32'h1, 1'b1);
        drive(0, 1'b1, 32'h2);
        waitDone(0);
        checkTransfer(0, 32'h1);
        for (int i = 0; i < 30 && acceptCnt[0] != startAcc + 2; i++) tick();
        checkOutput("b2b_second_accept", 64'(acceptCnt[0] - startAcc), 64'd2);
        @(posedge clk);
        #2;
        drive(0, 1'b0, 32'h2);
        waitDone(0);
        checkOutput("b2b_ss_gap", 64'(lastGap[0]), 64'(GAP));
        checkOutput("b2b_ready_cycles", 64'(lastReady[0]), 64'd1);
        checkTransfer(0, 32'h2);

        $display("[TB] reset in the middle of a transfer");
        rnd = $urandom;
        applyStimulus(0, rnd, 1'b0);
        target = acceptCyc[0] + 100;
        for (int i = 0; i < 200 && cyc != target; i++) @(posedge clk);
        #2;
        checkOutput("mid_transfer_state", {61'd0, ssV[0], readyV[0], busyV[0]}, 64'b001);
        startDone = doneCnt[0];
        reset = 1'b0;
        #1;
        checkOutput("async_reset_ss_sclk", {62'd0, ssV[0], sclkV[0]}, 64'b10);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        tick();
        checkOutput("ready_after_midreset", {62'd0, readyV[0], busyV[0]}, 64'b10);
        checkOutput("no_done_on_reset", 64'(doneCnt[0] - startDone), 64'd0);

        $display("[TB] CLK_DIV=1 instance");
        applyStimulus(1, 32'h8000_0001, 1'b0);
        waitDone(1);
        checkTransfer(1, 32'h8000_0001);
        rnd = $urandom;
        applyStimulus(1, rnd, 1'b0);
        waitDone(1);
        checkTransfer(1, rnd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
